matrix_scan_sequencer: RTL and testbench
========================================

Name: matrix_scan_sequencer

Overview:
- Sequencer that captures one packed M x N matrix and streams its elements one per handshake, in row-major or column-major (transpose) order.
- Drives the element-selection path used by the pseudoinverse datapath: it generates the (i, j) indices, the element value and the framing, so downstream MAC/accumulate stages consume the matrix serially.
- Column-major mode yields A-transpose order without a second matrix buffer.

Parameters:
M, 4, number of rows
N, 4, number of columns
nBits, 32, element width and index width

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request to capture matrix_in and begin a scan; sampled only in IDLE
mode  input  1  0 = row-major (j fastest), 1 = column-major (i fastest); captured with start
matrix_in  input  nBits*M*N  packed matrix; element (i,j) at bits [nBits*M*N-(N*i+j)*nBits-1 -: nBits] (row 0 col 0 in the MSBs)
out_valid  output  1  out_data/out_i/out_j/out_last valid
out_ready  input  1  downstream accepts the current element
out_data  output  nBits  element A[out_i][out_j]
out_i  output  nBits  row index of current element
out_j  output  nBits  column index of current element
out_last  output  1  high with the final element of the scan
busy  output  1  high from the cycle after start is accepted until the final transfer
done  output  1  single-cycle pulse, the cycle after the final transfer

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset, rst=1 at an edge: state IDLE; out_valid=0, out_last=0, busy=0, done=0; out_i=out_j=0; out_data=0; matrix register cleared.
- States: IDLE, STREAM.
- IDLE, start=1: latch matrix_in and mode into internal registers; set i=j=0; go to STREAM. At the next edge, out_valid=1 and busy=1 with element (0,0). Latency is 1 cycle from start to first valid.
- STREAM:
  - out_valid is held at 1.
  - A transfer occurs on each edge where out_valid && out_ready.
  - With no transfer, out_data, out_i, out_j and out_last hold their values.
- Index advance on transfer:
  - mode 0: j++; at j=N-1, set j=0 and i++.
  - mode 1: i++; at i=M-1, set i=0 and j++.
- out_data always equals the captured A[out_i][out_j]. It is a registered or combinational select from the captured register, and never reads the live matrix_in.
- out_last=1 exactly when (out_i,out_j)=(M-1,N-1), in both modes.
- Transfer while out_last=1:
  - next state IDLE; out_valid=0, busy=0, out_last=0; done=1 for one cycle.
  - Indices return to 0.
- Total transfers per scan = M*N, with no gaps imposed by the block. Back-to-back ready gives one element per cycle.
- start while in STREAM is ignored, with no restart and no queuing. start in the same cycle done is high is accepted, since the block is in IDLE.
- Changes to matrix_in or mode after capture have no effect on the current scan.
- rst asserted mid-scan aborts immediately to the reset values, with no done pulse.
- Degenerate M=1, N=1: the first element carries out_last=1 and done follows its transfer.
- Indices are zero-extended to nBits.

Test Plan:
- Row-major, M=N=4, A[i][j]=16*i+j, out_ready tied 1, start pulse -> out_valid rises 1 cycle later; out_data sequence 0,1,2,3,16,...,51 on 16 consecutive cycles; out_last only on 51 (i=3,j=3); done pulses 1 cycle after it; busy high for exactly 16 cycles.
- Column-major with the same matrix -> sequence 0,16,32,48,1,17,...,51; indices (0,0),(1,0),(2,0),(3,0),(0,1)...; out_last on (3,3).
- Backpressure: out_ready toggles 1,0,0,1,... -> outputs stable during every ready=0 cycle; no element skipped or repeated; exactly 16 transfers.
- Capture isolation: change matrix_in to all 0xFFFFFFFF one cycle after start -> streamed values are still the originally captured values.
- Ignored start and mid-scan reset:
  - start re-asserted at element 5 -> the scan continues unchanged.
  - rst at element 7 -> next cycle out_valid=0, busy=0, done=0.
  - A new start then begins again at (0,0).
- Degenerate M=1, N=1, A=0xDEADBEEF -> single beat carrying out_last=1, then a done pulse; start held high continuously -> a new scan begins in the cycle done is high.

Source files
------------

// File: rtl/matrix_scan_sequencer.sv
// matrix_scan_sequencer
// Captures one packed M x N matrix and streams its elements, one per
// valid/ready handshake, in row-major or column-major (transpose) order.
// Each beat carries the element value, its (i, j) indices and a last flag.

module matrix_scan_sequencer #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int nBits = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [nBits*M*N-1:0]   matrix_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [nBits-1:0]       out_data,
    output logic [nBits-1:0]       out_i,
    output logic [nBits-1:0]       out_j,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam int NE = M * N;
    localparam int LW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [nBits-1:0] IMAX = nBits'(M - 1);
    localparam logic [nBits-1:0] JMAX = nBits'(N - 1);

    state_t           state;
    logic             mode_q;
    logic [nBits-1:0] mat_q [NE];
    logic [nBits-1:0] i_q;
    logic [nBits-1:0] j_q;
    logic [nBits-1:0] ni;
    logic [nBits-1:0] nj;
    logic [LW-1:0]    lin;

    // Next (i, j) after a transfer: j fastest in mode 0, i fastest in mode 1
    always_comb begin
        ni = i_q;
        nj = j_q;
        if (!mode_q) begin
            if (j_q == JMAX) begin
                nj = '0;
                ni = i_q + 1'b1;
            end else begin
                nj = j_q + 1'b1;
            end
        end else begin
            if (i_q == IMAX) begin
                ni = '0;
                nj = j_q + 1'b1;
            end else begin
                ni = i_q + 1'b1;
            end
        end
    end

    // Element select from the captured copy; array index 0 is A[0][0]
    always_comb begin
        lin = LW'(i_q * N + j_q);
    end

    assign out_data = mat_q[lin];
    assign out_i    = i_q;
    assign out_j    = j_q;

    // Scan FSM: capture on start, advance indices on each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int unsigned k = 0; k < NE; k++) begin
                mat_q[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < NE; k++) begin
                            mat_q[k] <= matrix_in[(NE - 1 - k) * nBits +: nBits];
                        end
                        mode_q    <= mode;
                        i_q       <= '0;
                        j_q       <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= (NE == 1);
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            i_q       <= '0;
                            j_q       <= '0;
                        end else begin
                            i_q      <= ni;
                            j_q      <= nj;
                            out_last <= (ni == IMAX) && (nj == JMAX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// tb_matrix_scan_sequencer
// Directed scoreboard bench: expected beats are queued when a scan is
// started and popped as the DUT transfers them.

module tb_matrix_scan_sequencer;

    localparam int M = 4;
    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, mode, out_ready;
    logic [W*M*N-1:0] matrix_in;
    logic             out_valid, out_last, busy, done;
    logic [W-1:0]     out_data, out_i, out_j;

    logic             start1, ready1;
    logic [W-1:0]     matrix1;
    logic             valid1, last1, busy1, done1;
    logic [W-1:0]     data1, i1, j1;

    matrix_scan_sequencer #(.M(M), .N(N), .nBits(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .matrix_in(matrix_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_i(out_i), .out_j(out_j), .out_last(out_last), .busy(busy), .done(done)
    );

    matrix_scan_sequencer #(.M(1), .N(1), .nBits(W)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(1'b0), .matrix_in(matrix1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_i(i1), .out_j(j1), .out_last(last1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] i;
        logic [W-1:0] j;
        logic         last;
    } beat_t;

    beat_t        sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] a [M][N];
    int           nx, nb;

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic load_matrix();
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                a[i][j] = 16 * i + j;
                matrix_in[(M*N - 1 - (N*i + j)) * W +: W] = a[i][j];
            end
        end
    endtask

    task automatic push_scan(input logic md);
        beat_t b;
        if (!md) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    b.d = a[i][j]; b.i = i; b.j = j; b.last = (i == M-1) && (j == N-1);
                    sbq.push_back(b);
                end
        end else begin
            for (int j = 0; j < N; j++)
                for (int i = 0; i < M; i++) begin
                    b.d = a[i][j]; b.i = i; b.j = j; b.last = (i == M-1) && (j == N-1);
                    sbq.push_back(b);
                end
        end
    endtask

    // Pulse start for one cycle; optionally corrupt matrix_in/mode right after capture
    task automatic begin_scan(input logic md, input logic corrupt);
        @(negedge clk);
        chk1("idle_valid", out_valid, 1'b0);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        chk1("first_valid", out_valid, 1'b1);
        chk1("first_busy", busy, 1'b1);
        if (corrupt) begin
            matrix_in = '1;
            mode      = ~md;
        end
    endtask

    // pat 0: ready always 1; pat 1: ready 1,0,0 repeating
    task automatic run_scan(input int pat, input int start_at, input int rst_at,
                            output int xfers, output int busy_cyc);
        int           cyc;
        logic         prev_stall;
        logic [W-1:0] pd, pi, pj;
        logic         pl;
        beat_t        b;
        cyc = 0; prev_stall = 1'b0; xfers = 0; busy_cyc = 0;
        pd = '0; pi = '0; pj = '0; pl = 1'b0;
        while (sbq.size() > 0) begin
            if (cyc > 200) begin
                chkw("timeout_beats_left", sbq.size(), 0);
                sbq.delete();
                out_ready = 1'b0;
                return;
            end
            if (busy) busy_cyc++;
            if (prev_stall) begin
                chkw("stall_data", out_data, pd);
                chkw("stall_i", out_i, pi);
                chkw("stall_j", out_j, pj);
                chk1("stall_last", out_last, pl);
            end
            chk1("stream_valid", out_valid, 1'b1);
            start = (xfers == start_at);
            if (xfers == rst_at) begin
                rst = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                chk1("abort_valid", out_valid, 1'b0);
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_done", done, 1'b0);
                chk1("abort_last", out_last, 1'b0);
                chkw("abort_i", out_i, '0);
                chkw("abort_j", out_j, '0);
                chkw("abort_data", out_data, '0);
                sbq.delete();
                return;
            end
            out_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
            if (out_ready) begin
                b = sbq.pop_front();
                chkw("beat_data", out_data, b.d);
                chkw("beat_i", out_i, b.i);
                chkw("beat_j", out_j, b.j);
                chk1("beat_last", out_last, b.last);
                xfers++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                pd = out_data; pi = out_i; pj = out_j; pl = out_last;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk1("end_done", done, 1'b1);
        chk1("end_valid", out_valid, 1'b0);
        chk1("end_busy", busy, 1'b0);
        chk1("end_last", out_last, 1'b0);
        chkw("end_i", out_i, '0);
        chkw("end_j", out_j, '0);
        @(negedge clk);
        chk1("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        start1 = 1'b0; ready1 = 1'b1; matrix1 = 32'hDEADBEEF;
        load_matrix();
        repeat (2) @(negedge clk);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_last", out_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkw("rst_i", out_i, '0);
        chkw("rst_j", out_j, '0);
        chkw("rst_data", out_data, '0);
        chk1("rst_valid1", valid1, 1'b0);
        rst = 1'b0;

        // Row-major, ready tied high
        push_scan(1'b0);
        begin_scan(1'b0, 1'b0);
        run_scan(0, -1, -1, nx, nb);
        chkw("row_xfers", nx, 16);
        chkw("row_busy_cycles", nb, 16);

        // Column-major
        push_scan(1'b1);
        begin_scan(1'b1, 1'b0);
        run_scan(0, -1, -1, nx, nb);
        chkw("col_xfers", nx, 16);

        // Backpressure
        push_scan(1'b0);
        begin_scan(1'b0, 1'b0);
        run_scan(1, -1, -1, nx, nb);
        chkw("bp_xfers", nx, 16);

        // Capture isolation: matrix_in and mode change after capture
        push_scan(1'b0);
        begin_scan(1'b0, 1'b1);
        run_scan(0, -1, -1, nx, nb);
        chkw("iso_xfers", nx, 16);
        load_matrix();
        mode = 1'b0;

        // Ignored start at element 5, reset at element 7, then a fresh scan
        push_scan(1'b0);
        begin_scan(1'b0, 1'b0);
        run_scan(0, 5, 7, nx, nb);
        chkw("abort_xfers", nx, 7);
        push_scan(1'b0);
        begin_scan(1'b0, 1'b0);
        run_scan(0, -1, -1, nx, nb);
        chkw("restart_xfers", nx, 16);

        // Degenerate 1x1 with start held high
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        chk1("deg_valid", valid1, 1'b1);
        chk1("deg_last", last1, 1'b1);
        chk1("deg_busy", busy1, 1'b1);
        chkw("deg_data", data1, 32'hDEADBEEF);
        @(negedge clk);
        chk1("deg_done", done1, 1'b1);
        chk1("deg_done_valid", valid1, 1'b0);
        chk1("deg_done_busy", busy1, 1'b0);
        @(negedge clk);
        start1 = 1'b0;
        chk1("deg_restart_valid", valid1, 1'b1);
        chk1("deg_restart_last", last1, 1'b1);
        chk1("deg_restart_done", done1, 1'b0);
        chkw("deg_restart_data", data1, 32'hDEADBEEF);
        @(negedge clk);
        chk1("deg_done2", done1, 1'b1);
        @(negedge clk);
        chk1("deg_done2_clear", done1, 1'b0);
        chk1("deg_idle_valid", valid1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
